// File: rtl/uart_app_loader.sv
// UART boot loader: receives a framed 8N1 byte stream (sync, address, word count,
// data, checksum) and turns it into aligned 32-bit memory writes with a one-deep buffer.
module uart_app_loader #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        app_loaded,
  output logic        load_error,
  output logic        busy
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA, ST_CHK} state_t;

  rx_state_t rx_state, rx_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_valid, frame_err;

  // Receiver sequencing: start detection, mid-start recheck, 8 data bits, stop bit.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (bit_cnt == HALF_M1) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_cnt == FULL_M1 && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_cnt == FULL_M1) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Synchronizer resets high so a reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      rx_meta    <= uart_rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
        end
        RX_START: bit_cnt <= (bit_cnt == HALF_M1) ? '0 : bit_cnt + 1'b1;
        RX_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt    <= '0;
            byte_valid <= rx_sync;
            frame_err  <= ~rx_sync;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  state_t state, next_state;
  logic [31:0] base_q, word_q;
  logic [15:0] count_q, word_idx;
  logic [15:0] count_full;
  logic [7:0]  sum_q;
  logic [1:0]  idx_q;
  logic        chk_seen, chk_ok;
  logic        handshake, stalled;
  logic        clear_frame, set_loaded, set_error, abort_write;
  logic        take_byte, word_done, chk_hold;

  assign handshake  = mem_wvalid & mem_wready;
  assign stalled    = mem_wvalid & ~mem_wready;
  assign count_full = {rx_byte, count_q[15:8]};
  assign busy       = (state != ST_IDLE);

  // Frame parser; a framing error outside IDLE overrides whatever the state would do.
  always_comb begin
    next_state  = state;
    clear_frame = 1'b0;
    set_loaded  = 1'b0;
    set_error   = 1'b0;
    abort_write = 1'b0;
    take_byte   = 1'b0;
    word_done   = 1'b0;
    chk_hold    = 1'b0;
    if (state != ST_IDLE && frame_err) begin
      next_state  = ST_IDLE;
      set_error   = 1'b1;
      abort_write = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (byte_valid && rx_byte == SYNC_BYTE) begin
            next_state  = ST_ADDR;
            clear_frame = 1'b1;
          end
        end
        ST_ADDR: begin
          if (byte_valid) begin
            take_byte = 1'b1;
            if (idx_q == 2'd3) next_state = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (byte_valid) begin
            take_byte = 1'b1;
            if (idx_q == 2'd1) next_state = (count_full == 16'd0) ? ST_CHK : ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            take_byte = 1'b1;
            if (idx_q == 2'd3) begin
              if (stalled) begin
                next_state  = ST_IDLE;
                set_error   = 1'b1;
                abort_write = 1'b1;
              end else begin
                word_done = 1'b1;
                if (word_idx == count_q - 16'd1) next_state = ST_CHK;
              end
            end
          end
        end
        ST_CHK: begin
          // The verdict waits for the last write to drain.
          if (chk_seen) begin
            if (handshake) begin
              next_state = ST_IDLE;
              set_loaded = chk_ok;
              set_error  = ~chk_ok;
            end
          end else if (byte_valid) begin
            if (stalled) begin
              chk_hold = 1'b1;
            end else begin
              next_state = ST_IDLE;
              set_loaded = (rx_byte == sum_q);
              set_error  = (rx_byte != sum_q);
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wvalid <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      app_loaded <= 1'b0;
      load_error <= 1'b0;
      base_q     <= '0;
      word_q     <= '0;
      count_q    <= '0;
      word_idx   <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      chk_seen   <= 1'b0;
      chk_ok     <= 1'b0;
    end else begin
      if (handshake || abort_write) mem_wvalid <= 1'b0;
      if (clear_frame) begin
        app_loaded <= 1'b0;
        load_error <= 1'b0;
        sum_q      <= '0;
        idx_q      <= '0;
        word_idx   <= '0;
      end
      if (set_loaded) app_loaded <= 1'b1;
      if (set_error)  load_error <= 1'b1;
      if (take_byte) begin
        sum_q <= sum_q + rx_byte;
        idx_q <= (state == ST_COUNT && idx_q == 2'd1) ? 2'd0 : idx_q + 2'd1;
        case (state)
          ST_ADDR:  base_q  <= {rx_byte, base_q[31:8]};
          ST_COUNT: count_q <= count_full;
          ST_DATA:  word_q  <= {rx_byte, word_q[31:8]};
          default:  ;
        endcase
      end
      // Low address bits of the base never carry, so masking after the add aligns it.
      if (word_done) begin
        mem_wdata  <= {rx_byte, word_q[31:8]};
        mem_waddr  <= (base_q + {14'd0, word_idx, 2'b00}) & 32'hFFFF_FFFC;
        mem_wvalid <= 1'b1;
        word_idx   <= word_idx + 16'd1;
      end
      if (chk_hold) begin
        chk_seen <= 1'b1;
        chk_ok   <= (rx_byte == sum_q);
      end else if (next_state == ST_IDLE) begin
        chk_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_app_loader.sv
// Directed bench for uart_app_loader at 10 clocks per bit: bytes are bit-banged onto
// uart_rx and the observed write handshakes and status flags are checked against hand values.
module tb_uart_app_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        app_loaded;
  logic        load_error;
  logic        busy;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  int ready_mode   = 0;
  int wait_cnt     = 0;
  int stall_cycles = 0;
  int bv_count     = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_addr  = '0;
  logic [31:0] hold_data  = '0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  frame_q[$];

  uart_app_loader #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .app_loaded (app_loaded),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_cnt++;
    assert (observed === expected) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Ready policy: 0 always ready, 1 ready after 30 stalled cycles, 2 never ready.
  always @(negedge clk) begin
    if (ready_mode == 0) begin
      mem_wready = 1'b1;
    end else if (ready_mode == 1 && mem_wvalid) begin
      if (wait_cnt < 30) begin
        mem_wready = 1'b0;
        wait_cnt++;
      end else begin
        mem_wready = 1'b1;
      end
    end else begin
      mem_wready = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (dut.byte_valid) bv_count++;
    if (!rst && mem_wvalid && mem_wready) begin
      wr_addr_q.push_back(mem_waddr);
      wr_data_q.push_back(mem_wdata);
    end
    if (!rst && mem_wvalid && !mem_wready) begin
      if (stall_prev) begin
        checkOutput("stall_addr_stable", mem_waddr, hold_addr);
        checkOutput("stall_data_stable", mem_wdata, hold_data);
      end
      stall_prev = 1'b1;
      hold_addr = mem_waddr;
      hold_data = mem_wdata;
      stall_cycles++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) applyStimulus(frame_q[i], 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_two_writes(input string tag, input logic [31:0] a0, input logic [31:0] d0,
                                  input logic [31:0] a1, input logic [31:0] d1);
    checkOutput({tag, "_nwr"}, wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      checkOutput({tag, "_addr0"}, wr_addr_q[0], a0);
      checkOutput({tag, "_data0"}, wr_data_q[0], d0);
      checkOutput({tag, "_addr1"}, wr_addr_q[1], a1);
      checkOutput({tag, "_data1"}, wr_data_q[1], d1);
    end
  endtask

  initial begin
    int bv_before;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_wvalid", {31'd0, mem_wvalid}, 32'd0);
    checkOutput("reset_waddr", mem_waddr, 32'd0);
    checkOutput("reset_wdata", mem_wdata, 32'd0);
    checkOutput("reset_flags", {29'd0, app_loaded, load_error, busy}, 32'd0);

    // Basic load, checksum 0xDE
    ready_mode = 0;
    clear_log();
    applyStimulus(8'hA5, 1'b1);
    checkOutput("basic_busy_after_sync", {31'd0, busy}, 32'd1);
    frame_q = '{8'h00, 8'h10, 8'h00, 8'h80, 8'h02, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hDE};
    send_frame();
    wait_idle("basic_idle");
    check_two_writes("basic", 32'h8000_1000, 32'h1234_5678, 32'h8000_1004, 32'hDEAD_BEEF);
    checkOutput("basic_loaded", {31'd0, app_loaded}, 32'd1);
    checkOutput("basic_error", {31'd0, load_error}, 32'd0);

    // Back-pressure, 30 stall cycles per word
    ready_mode = 1;
    clear_log();
    stall_cycles = 0;
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h80, 8'h02, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hDE};
    send_frame();
    wait_idle("bp_idle");
    check_two_writes("bp", 32'h8000_1000, 32'h1234_5678, 32'h8000_1004, 32'hDEAD_BEEF);
    checkOutput("bp_stalled", {31'd0, stall_cycles >= 50}, 32'd1);
    checkOutput("bp_loaded", {31'd0, app_loaded}, 32'd1);

    // Overrun: never ready, second word completes over the pending first
    ready_mode = 2;
    clear_log();
    send_frame();
    checkOutput("ovr_error", {31'd0, load_error}, 32'd1);
    checkOutput("ovr_loaded", {31'd0, app_loaded}, 32'd0);
    checkOutput("ovr_busy", {31'd0, busy}, 32'd0);
    checkOutput("ovr_wvalid", {31'd0, mem_wvalid}, 32'd0);
    checkOutput("ovr_nwr", wr_addr_q.size(), 32'd0);

    // Bad checksum
    ready_mode = 0;
    clear_log();
    frame_q[15] = 8'hDF;
    send_frame();
    wait_idle("badchk_idle");
    check_two_writes("badchk", 32'h8000_1000, 32'h1234_5678, 32'h8000_1004, 32'hDEAD_BEEF);
    checkOutput("badchk_error", {31'd0, load_error}, 32'd1);
    checkOutput("badchk_loaded", {31'd0, app_loaded}, 32'd0);

    // Framing error inside ADDR
    clear_log();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h10, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("frm_error", {31'd0, load_error}, 32'd1);
    checkOutput("frm_busy", {31'd0, busy}, 32'd0);
    checkOutput("frm_nwr", wr_addr_q.size(), 32'd0);

    // COUNT = 0, checksum = 0x20
    clear_log();
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame();
    checkOutput("cnt0_loaded", {31'd0, app_loaded}, 32'd1);
    checkOutput("cnt0_error", {31'd0, load_error}, 32'd0);
    checkOutput("cnt0_nwr", wr_addr_q.size(), 32'd0);

    // Glitch in IDLE
    bv_before = bv_count;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("glitch_no_byte", bv_count - bv_before, 32'd0);
    checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
    checkOutput("glitch_loaded_kept", {31'd0, app_loaded}, 32'd1);

    // Address wrap, checksum 0xFE
    clear_log();
    frame_q = '{8'hA5, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
                8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFE};
    send_frame();
    check_two_writes("wrap", 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002);
    checkOutput("wrap_loaded", {31'd0, app_loaded}, 32'd1);

    // Unaligned base 0x03, one word, checksum 0x12
    clear_log();
    frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h12};
    send_frame();
    checkOutput("unal_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      checkOutput("unal_addr", wr_addr_q[0], 32'h0000_0000);
      checkOutput("unal_data", wr_data_q[0], 32'hDDCC_BBAA);
    end
    checkOutput("unal_loaded", {31'd0, app_loaded}, 32'd1);

    // Reset mid-frame with a write pending
    ready_mode = 2;
    clear_log();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h80, 8'h02, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12};
    send_frame();
    for (int n = 0; n < 500 && !mem_wvalid; n++) @(negedge clk);
    checkOutput("rst_wvalid_pending", {31'd0, mem_wvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_wvalid", {31'd0, mem_wvalid}, 32'd0);
    checkOutput("rst_mid_waddr", mem_waddr, 32'd0);
    checkOutput("rst_mid_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mid_flags", {29'd0, app_loaded, load_error, busy}, 32'd0);

    ready_mode = 0;
    clear_log();
    repeat (5) @(negedge clk);
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h80, 8'h02, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hDE};
    send_frame();
    wait_idle("post_rst_idle");
    check_two_writes("post_rst", 32'h8000_1000, 32'h1234_5678, 32'h8000_1004, 32'hDEAD_BEEF);
    checkOutput("post_rst_loaded", {31'd0, app_loaded}, 32'd1);
    checkOutput("post_rst_error", {31'd0, load_error}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
